hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: derives stall/flush/next-PC controls from load-use,
// branch, trap/mret and LSU-busy events, and counts stall and redirect cycles.
module hazard_ctrl #(
    parameter int unsigned TRAP_FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_dependence,
    input  logic             ex_br_take,
    input  logic             mem_trap,
    input  logic             mem_mret,
    input  logic             lsu_busy,
    output logic             if_stall,
    output logic             id_stall,
    output logic             ex_stall,
    output logic             if_flush,
    output logic             id_flush,
    output logic             ex_flush,
    output logic [1:0]       pc_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam int unsigned FC_W = $clog2(TRAP_FLUSH_CYCLES) + 1;
    localparam logic [FC_W-1:0] FC_INIT = FC_W'(TRAP_FLUSH_CYCLES - 1);

    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_MTVEC = 2'b10;
    localparam logic [1:0] PC_MEPC  = 2'b11;

    typedef enum logic [1:0] {
        RUN,
        LSU_WAIT,
        TRAP_FLUSH
    } state_e;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, redirect_cnt_q;

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path infers a latch.
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        if_stall = 1'b0;
        id_stall = 1'b0;
        ex_stall = 1'b0;
        if_flush = 1'b0;
        id_flush = 1'b0;
        ex_flush = 1'b0;
        pc_sel   = PC_SEQ;

        // Outputs are gated by rst so they drop immediately when reset asserts.
        if (rst) begin
            case (state_q)
                TRAP_FLUSH: begin
                    if_flush = 1'b1;
                    id_flush = 1'b1;
                    ex_flush = 1'b1;
                    if (fcnt_q <= FC_W'(1)) begin
                        state_d = RUN;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q - FC_W'(1);
                    end
                end
                default: begin
                    // RUN and LSU_WAIT share one priority chain; LSU_WAIT with
                    // lsu_busy low falls through to the RUN rules in the same cycle.
                    if (mem_trap || mem_mret) begin
                        if_flush = 1'b1;
                        id_flush = 1'b1;
                        ex_flush = 1'b1;
                        pc_sel   = mem_trap ? PC_MTVEC : PC_MEPC;
                        if (TRAP_FLUSH_CYCLES > 1) begin
                            state_d = TRAP_FLUSH;
                            fcnt_d  = FC_INIT;
                        end else begin
                            state_d = RUN;
                            fcnt_d  = '0;
                        end
                    end else if (lsu_busy) begin
                        if_stall = 1'b1;
                        id_stall = 1'b1;
                        ex_stall = 1'b1;
                        state_d  = LSU_WAIT;
                    end else begin
                        state_d = RUN;
                        if (ex_br_take) begin
                            pc_sel   = PC_BR;
                            if_flush = 1'b1;
                            id_flush = 1'b1;
                        end else if (load_dependence) begin
                            if_stall = 1'b1;
                            id_stall = 1'b1;
                            id_flush = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments and is cleared by the async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            fcnt_q         <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (if_stall)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (pc_sel != PC_SEQ)
                redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule
